// File: rtl/smi_write_req_arbiter.sv
// Merges NumPorts client SMI write-request streams frame by frame (round robin) onto one channel.
// Request tags are swapped for slot indices; responses are routed back to the client with the original tag.
module smi_write_req_arbiter #(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned SlotIndexSize = 2
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [NumPorts-1:0]           clientReqReady,
  input  logic [8*NumPorts-1:0]         clientReqEofc,
  input  logic [DataWidth*NumPorts-1:0] clientReqData,
  output logic [NumPorts-1:0]           clientReqStop,
  output logic                          smiReqReady,
  output logic [7:0]                    smiReqEofc,
  output logic [DataWidth-1:0]          smiReqData,
  input  logic                          smiReqStop,
  input  logic                          smiRespReady,
  input  logic [7:0]                    smiRespEofc,
  input  logic [DataWidth-1:0]          smiRespData,
  output logic                          smiRespStop,
  output logic [NumPorts-1:0]           clientRespReady,
  output logic [8*NumPorts-1:0]         clientRespEofc,
  output logic [DataWidth*NumPorts-1:0] clientRespData,
  input  logic [NumPorts-1:0]           clientRespStop
);
  localparam int unsigned TagSlots = 1 << SlotIndexSize;
  localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_FWD   = 1'b1;

  logic [0:0]               r_state, w_state_nxt;
  logic [PortW-1:0]         r_ptr, w_ptr_nxt;
  logic [PortW-1:0]         r_grant, w_grant_nxt;
  logic [SlotIndexSize-1:0] r_slot, w_slot_nxt;
  logic                     r_first, w_first_nxt;

  logic [TagSlots-1:0]      r_busy;
  logic [PortW-1:0]         r_tbl_port [TagSlots];
  logic [15:0]              r_tbl_tag  [TagSlots];

  logic                     r_req_vld;
  logic [7:0]               r_req_eofc;
  logic [DataWidth-1:0]     r_req_data;

  logic [NumPorts-1:0]      r_crsp_vld;
  logic [7:0]               r_crsp_eofc [NumPorts];
  logic [DataWidth-1:0]     r_crsp_data [NumPorts];

  logic [DataWidth-1:0]     w_cdata [NumPorts];
  logic [7:0]               w_ceofc [NumPorts];
  logic [DataWidth-1:0]     w_cur_data, w_fwd_data, w_rsp_data;
  logic [7:0]               w_cur_eofc;
  logic                     w_out_load, w_req_xfer;
  logic                     w_cand_found, w_slot_found;
  logic [PortW-1:0]         w_cand_port;
  logic [SlotIndexSize-1:0] w_free_slot, w_rsp_slot;
  logic                     w_rsp_hit, w_rsp_xfer;
  logic [PortW-1:0]         w_rsp_port;
  int                       w_idx;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign w_cdata[p] = clientReqData[p*DataWidth +: DataWidth];
    assign w_ceofc[p] = clientReqEofc[p*8 +: 8];
    assign clientRespData[p*DataWidth +: DataWidth] = r_crsp_data[p];
    assign clientRespEofc[p*8 +: 8]                 = r_crsp_eofc[p];
  end

  assign w_cur_data  = w_cdata[r_grant];
  assign w_cur_eofc  = w_ceofc[r_grant];
  assign w_out_load  = !r_req_vld || !smiReqStop;
  assign w_req_xfer  = (r_state == ST_FWD) && !srst && clientReqReady[r_grant] && w_out_load;

  assign smiReqReady     = r_req_vld;
  assign smiReqEofc      = r_req_eofc;
  assign smiReqData      = r_req_data;
  assign clientRespReady = r_crsp_vld;

  // Round-robin candidate search starting at the pointer, plus lowest free slot
  always_comb begin : arb
    w_cand_found = 1'b0;
    w_cand_port  = '0;
    w_idx        = 0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= int'(NumPorts)) w_idx = w_idx - int'(NumPorts);
      if (!w_cand_found && clientReqReady[PortW'(w_idx)]) begin
        w_cand_found = 1'b1;
        w_cand_port  = PortW'(w_idx);
      end
    end
    w_slot_found = 1'b0;
    w_free_slot  = '0;
    for (int s = int'(TagSlots) - 1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        w_slot_found = 1'b1;
        w_free_slot  = SlotIndexSize'(s);
      end
    end
  end

  always_comb begin : fsm_nxt
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_slot_nxt  = r_slot;
    w_first_nxt = r_first;
    case (r_state)
      ST_IDLE: begin
        if (w_cand_found && w_slot_found) begin
          w_state_nxt = ST_FWD;
          w_grant_nxt = w_cand_port;
          w_slot_nxt  = w_free_slot;
          w_first_nxt = 1'b1;
        end
      end
      ST_FWD: begin
        if (w_req_xfer) w_first_nxt = 1'b0;
        if (w_req_xfer && (w_cur_eofc != 8'd0)) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_grant == PortW'(NumPorts - 1)) ? '0 : r_grant + PortW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_reg
    if (srst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_slot  <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_slot  <= w_slot_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin : req_stop
    clientReqStop = '1;
    if ((r_state == ST_FWD) && !srst) clientReqStop[r_grant] = !w_out_load;
  end

  // First flit of a frame carries the slot index in place of the client tag
  always_comb begin : fwd_data
    w_fwd_data = w_cur_data;
    if (r_first) w_fwd_data[31:16] = 16'(r_slot);
  end

  always_ff @(posedge clk) begin : req_out
    if (srst) begin
      r_req_vld <= 1'b0;
    end else if (w_out_load) begin
      r_req_vld  <= w_req_xfer;
      r_req_eofc <= w_cur_eofc;
      r_req_data <= w_fwd_data;
    end
  end

  assign w_rsp_slot  = smiRespData[SlotIndexSize+15:16];
  assign w_rsp_hit   = r_busy[w_rsp_slot];
  assign w_rsp_port  = r_tbl_port[w_rsp_slot];
  assign smiRespStop = w_rsp_hit && r_crsp_vld[w_rsp_port] && clientRespStop[w_rsp_port];
  assign w_rsp_xfer  = smiRespReady && !smiRespStop;

  always_comb begin : rsp_data
    w_rsp_data        = smiRespData;
    w_rsp_data[31:16] = r_tbl_tag[w_rsp_slot];
  end

  // Allocation wins over a same-cycle free of the same slot (only a stray response can collide)
  always_ff @(posedge clk) begin : tag_table
    if (srst) begin
      r_busy <= '0;
    end else begin
      if (w_rsp_xfer && w_rsp_hit) r_busy[w_rsp_slot] <= 1'b0;
      if (w_req_xfer && r_first) begin
        r_busy[r_slot]     <= 1'b1;
        r_tbl_port[r_slot] <= r_grant;
        r_tbl_tag[r_slot]  <= w_cur_data[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin : rsp_out
    if (srst) begin
      r_crsp_vld <= '0;
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (w_rsp_xfer && w_rsp_hit && (w_rsp_port == PortW'(p))) begin
          r_crsp_vld[p]  <= 1'b1;
          r_crsp_eofc[p] <= smiRespEofc;
          r_crsp_data[p] <= w_rsp_data;
        end else if (!clientRespStop[p]) begin
          r_crsp_vld[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_smi_write_req_arbiter.sv
// Directed self-checking bench for smi_write_req_arbiter (2 ports, 64-bit flits, 4 tag slots).
module tb_smi_write_req_arbiter;
  logic         clk = 1'b0;
  logic         srst;
  logic [1:0]   clientReqReady;
  logic [15:0]  clientReqEofc;
  logic [127:0] clientReqData;
  logic [1:0]   clientReqStop;
  logic         smiReqReady;
  logic [7:0]   smiReqEofc;
  logic [63:0]  smiReqData;
  logic         smiReqStop;
  logic         smiRespReady;
  logic [7:0]   smiRespEofc;
  logic [63:0]  smiRespData;
  logic         smiRespStop;
  logic [1:0]   clientRespReady;
  logic [15:0]  clientRespEofc;
  logic [127:0] clientRespData;
  logic [1:0]   clientRespStop;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] q_sdata [$];
  logic [7:0]  q_seofc [$];
  int          q_cport [$];

  always #5 clk = ~clk;

  smi_write_req_arbiter #(.NumPorts(2), .DataWidth(64), .SlotIndexSize(2)) dut (
    .clk(clk), .srst(srst),
    .clientReqReady(clientReqReady), .clientReqEofc(clientReqEofc),
    .clientReqData(clientReqData), .clientReqStop(clientReqStop),
    .smiReqReady(smiReqReady), .smiReqEofc(smiReqEofc), .smiReqData(smiReqData),
    .smiReqStop(smiReqStop),
    .smiRespReady(smiRespReady), .smiRespEofc(smiRespEofc), .smiRespData(smiRespData),
    .smiRespStop(smiRespStop),
    .clientRespReady(clientRespReady), .clientRespEofc(clientRespEofc),
    .clientRespData(clientRespData), .clientRespStop(clientRespStop)
  );

  // Record every accepted flit on the merged channel and every accepted client flit
  always @(posedge clk) begin
    if (!srst && smiReqReady && !smiReqStop) begin
      q_sdata.push_back(smiReqData);
      q_seofc.push_back(smiReqEofc);
    end
    if (!srst) begin
      for (int p = 0; p < 2; p++)
        if (clientReqReady[p] && !clientReqStop[p]) q_cport.push_back(p);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_q();
    q_sdata.delete();
    q_seofc.delete();
    q_cport.delete();
  endtask

  // Present one flit on port p and hold it until accepted (bounded)
  task automatic send_flit(input int p, input logic [63:0] d, input logic [7:0] e);
    int n;
    n = 0;
    clientReqReady[p]       = 1'b1;
    clientReqData[p*64 +: 64] = d;
    clientReqEofc[p*8 +: 8]   = e;
    #1;
    while (clientReqStop[p] && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk("req_accept_timeout", 64'(n >= 40), 64'd0);
    tick();
    clientReqReady[p] = 1'b0;
  endtask

  task automatic send_resp(input logic [63:0] d, input logic [7:0] e);
    int n;
    n = 0;
    smiRespReady = 1'b1;
    smiRespData  = d;
    smiRespEofc  = e;
    #1;
    while (smiRespStop && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk("resp_accept_timeout", 64'(n >= 40), 64'd0);
    tick();
    smiRespReady = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst = 1'b1;
    clientReqReady = '0; clientReqEofc = '0; clientReqData = '0;
    smiReqStop = 1'b0; smiRespReady = 1'b0; smiRespEofc = '0; smiRespData = '0;
    clientRespStop = '0;
    @(negedge clk);
    tick();
    tick();
    srst = 1'b0;

    // Reset state
    chk("rst_smiReqReady", 64'(smiReqReady), 64'd0);
    chk("rst_clientRespReady", 64'(clientRespReady), 64'd0);
    chk("rst_clientReqStop", 64'(clientReqStop), 64'h3);
    chk("rst_smiRespStop", 64'(smiRespStop), 64'd0);

    // Single client, 3-flit frame, tag 0x1234 becomes slot 0
    clear_q();
    send_flit(0, 64'hA0A0_A0A0_1234_5678, 8'h00);
    send_flit(0, 64'hB1B1_B1B1_B1B1_B1B1, 8'h00);
    send_flit(0, 64'hC2C2_C2C2_C2C2_C2C2, 8'h08);
    tick();
    tick();
    chk("single_count", 64'(q_sdata.size()), 64'd3);
    chk("single_flit0", q_sdata[0], 64'hA0A0_A0A0_0000_5678);
    chk("single_flit1", q_sdata[1], 64'hB1B1_B1B1_B1B1_B1B1);
    chk("single_flit2", q_sdata[2], 64'hC2C2_C2C2_C2C2_C2C2);
    chk("single_eofc0", 64'(q_seofc[0]), 64'd0);
    chk("single_eofc2", 64'(q_seofc[2]), 64'h08);
    chk("single_idle_stop", 64'(clientReqStop), 64'h3);

    send_resp(64'hDEAD_BEEF_0000_0042, 8'h04);
    chk("single_rsp_ready", 64'(clientRespReady), 64'h1);
    chk("single_rsp_data", clientRespData[63:0], 64'hDEAD_BEEF_1234_0042);
    chk("single_rsp_eofc", 64'(clientRespEofc[7:0]), 64'h04);
    tick();
    chk("single_rsp_drain", 64'(clientRespReady), 64'd0);

    // Fairness: both ports always ready with single-flit frames until the table fills
    do_reset();
    clear_q();
    clientReqData  = {64'h0000_00B1_0B01_00B1, 64'h0000_00A0_0A00_00A0};
    clientReqEofc  = {8'h01, 8'h01};
    clientReqReady = 2'b11;
    repeat (12) tick();
    #1;
    chk("fair_count", 64'(q_cport.size()), 64'd4);
    chk("fair_g0", 64'(q_cport[0]), 64'd0);
    chk("fair_g1", 64'(q_cport[1]), 64'd1);
    chk("fair_g2", 64'(q_cport[2]), 64'd0);
    chk("fair_g3", 64'(q_cport[3]), 64'd1);
    chk("fair_s0", q_sdata[0], 64'h0000_00A0_0000_00A0);
    chk("fair_s1", q_sdata[1], 64'h0000_00B1_0001_00B1);
    chk("fair_s2", q_sdata[2], 64'h0000_00A0_0002_00A0);
    chk("fair_s3", q_sdata[3], 64'h0000_00B1_0003_00B1);
    chk("full_stop", 64'(clientReqStop), 64'h3);

    // Free slot 2; it is allocated on the following cycle
    smiRespReady = 1'b1;
    smiRespData  = 64'h5555_0000_0002_7777;
    smiRespEofc  = 8'h04;
    #1;
    chk("full_rsp_stop", 64'(smiRespStop), 64'd0);
    tick();
    smiRespReady = 1'b0;
    chk("full_rsp_ready", 64'(clientRespReady), 64'h1);
    chk("full_rsp_data", clientRespData[63:0], 64'h5555_0000_0A00_7777);
    chk("free_same_cycle_stop", 64'(clientReqStop), 64'h3);
    tick();
    chk("free_next_grant", 64'(clientReqStop), 64'h2);
    tick();
    clientReqReady = 2'b00;
    tick();
    chk("free_count", 64'(q_sdata.size()), 64'd5);
    chk("free_slot2", q_sdata[4], 64'h0000_00A0_0002_00A0);

    // Out-of-order responses: slot 0 owned by port 1, slot 1 by port 0
    do_reset();
    clear_q();
    send_flit(1, 64'h0000_0000_7777_0000, 8'h01);
    send_flit(0, 64'h0000_0000_3333_0000, 8'h01);
    tick();
    tick();
    chk("ooo_s0", q_sdata[0], 64'h0000_0000_0000_0000);
    chk("ooo_s1", q_sdata[1], 64'h0000_0000_0001_0000);
    send_resp(64'h0000_0000_0001_0000, 8'h02);
    chk("ooo_p0_ready", 64'(clientRespReady), 64'h1);
    chk("ooo_p0_data", clientRespData[63:0], 64'h0000_0000_3333_0000);
    send_resp(64'h0000_0000_0000_0000, 8'h02);
    chk("ooo_p1_ready", 64'(clientRespReady), 64'h2);
    chk("ooo_p1_data", clientRespData[127:64], 64'h0000_0000_7777_0000);
    chk("ooo_p1_eofc", 64'(clientRespEofc[15:8]), 64'h02);
    tick();

    // Request backpressure for 5 cycles mid-frame
    do_reset();
    clear_q();
    send_flit(0, 64'h0101_0101_ABCD_0101, 8'h00);
    send_flit(0, 64'h0202_0202_0202_0202, 8'h00);
    smiReqStop = 1'b1;
    fork
      begin
        send_flit(0, 64'h0303_0303_0303_0303, 8'h00);
        send_flit(0, 64'h0404_0404_0404_0404, 8'h10);
      end
      begin
        repeat (3) tick();
        chk("bp_hold_ready", 64'(smiReqReady), 64'd1);
        chk("bp_hold_data", smiReqData, 64'h0202_0202_0202_0202);
        chk("bp_hold_stop", 64'(clientReqStop), 64'h3);
        repeat (2) tick();
        smiReqStop = 1'b0;
      end
    join
    tick();
    tick();
    chk("bp_count", 64'(q_sdata.size()), 64'd4);
    chk("bp_f0", q_sdata[0], 64'h0101_0101_0000_0101);
    chk("bp_f1", q_sdata[1], 64'h0202_0202_0202_0202);
    chk("bp_f2", q_sdata[2], 64'h0303_0303_0303_0303);
    chk("bp_f3", q_sdata[3], 64'h0404_0404_0404_0404);
    chk("bp_eofc3", 64'(q_seofc[3]), 64'h10);

    // Response backpressure on port 1 (slots 1 and 2 owned by port 1)
    send_flit(1, 64'h0000_0000_1111_0000, 8'h01);
    send_flit(1, 64'h0000_0000_2222_0000, 8'h01);
    tick();
    tick();
    clientRespStop = 2'b10;
    smiRespReady   = 1'b1;
    smiRespEofc    = 8'h01;
    smiRespData    = 64'hCAFE_0000_0001_0000;
    #1;
    chk("rbp_empty_stop", 64'(smiRespStop), 64'd0);
    tick();
    smiRespData = 64'hCAFE_0000_0002_0000;
    #1;
    chk("rbp_full_stop", 64'(smiRespStop), 64'd1);
    chk("rbp_full_ready", 64'(clientRespReady), 64'h2);
    chk("rbp_full_data", clientRespData[127:64], 64'hCAFE_0000_1111_0000);
    smiRespData = 64'hCAFE_0000_0000_0000;
    #1;
    chk("rbp_other_port_stop", 64'(smiRespStop), 64'd0);
    smiRespData    = 64'hCAFE_0000_0002_0000;
    clientRespStop = 2'b00;
    #1;
    chk("rbp_release_stop", 64'(smiRespStop), 64'd0);
    tick();
    smiRespReady = 1'b0;
    chk("rbp_second_ready", 64'(clientRespReady), 64'h2);
    chk("rbp_second_data", clientRespData[127:64], 64'hCAFE_0000_2222_0000);
    tick();
    chk("rbp_drain", 64'(clientRespReady), 64'd0);

    // Reset mid-frame after two flits of a four-flit frame
    clear_q();
    send_flit(0, 64'h1000_0000_5A5A_0001, 8'h00);
    send_flit(0, 64'h1000_0000_0000_0002, 8'h00);
    clientReqReady[0]    = 1'b1;
    clientReqData[63:0]  = 64'h1000_0000_0000_0003;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    #1;
    chk("mrst_smiReqReady", 64'(smiReqReady), 64'd0);
    chk("mrst_clientReqStop", 64'(clientReqStop), 64'h3);
    chk("mrst_respReady", 64'(clientRespReady), 64'd0);
    clientReqReady = 2'b00;

    // Response to a now-free slot is consumed and dropped
    smiRespReady = 1'b1;
    smiRespData  = 64'h0000_0000_0003_0000;
    smiRespEofc  = 8'h01;
    #1;
    chk("stray_rsp_stop", 64'(smiRespStop), 64'd0);
    tick();
    smiRespReady = 1'b0;
    chk("stray_rsp_ready", 64'(clientRespReady), 64'd0);

    clear_q();
    send_flit(0, 64'h2000_0000_BEEF_0000, 8'h01);
    tick();
    tick();
    chk("mrst_new_count", 64'(q_sdata.size()), 64'd1);
    chk("mrst_new_slot0", q_sdata[0], 64'h2000_0000_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
